ahb_master_mux: RTL and testbench
=================================

AHB_MASTER_MUX -- requirements
Module: ahb_master_mux

Interface
REQ-001 SHALL have parameter NMASTERS, default 16: number of bus masters.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have port HCLK, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port HRESET, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port HMASTER, input, 4: granted master, from the arbiter.
REQ-007 SHALL have port HREADY, input, 1: transfer-complete handshake.
REQ-008 SHALL have port HADDRx, input, NMASTERS*AW: per-master address, master i in slice i.
REQ-009 SHALL have port HTRANSx, input, NMASTERS*2: per-master transfer type.
REQ-010 SHALL have port HWRITEx, input, NMASTERS: per-master write flag.
REQ-011 SHALL have port HSIZEx, input, NMASTERS*3: per-master transfer size.
REQ-012 SHALL have port HBURSTx, input, NMASTERS*3: per-master burst type.
REQ-013 SHALL have port HWDATAx, input, NMASTERS*DW: per-master write data.
REQ-014 SHALL have outputs HADDR (AW), HTRANS (2), HWRITE (1), HSIZE (3), HBURST (3): muxed address/control.
REQ-015 SHALL have output HWDATA, DW: muxed write data.
REQ-016 SHALL have output HMASTER_D, 4: data-phase master.
REQ-017 SHALL have output BURST_ACTIVE, 1: a burst is being tracked.
REQ-018 SHALL have output BEATS_LEFT, 4: beats remaining in a fixed-length burst.
REQ-019 SHALL have outputs EARLY_TERM (1) and SEQ_ERR (1): registered one-cycle error pulses.

Function
REQ-020 SHALL drive the address/control outputs combinationally from slice HMASTER (zero latency).
REQ-021 SHALL drive all address/control outputs to 0 (HTRANS=IDLE) when HMASTER >= NMASTERS.
REQ-022 SHALL load HMASTER_D <= HMASTER on a rising edge with HREADY=1, and hold it while HREADY=0.
REQ-023 SHALL drive HWDATA combinationally from slice HMASTER_D; it SHALL drive 0 when HMASTER_D >= NMASTERS.
REQ-024 SHALL define "accepted" as HREADY=1 with HTRANS in {NONSEQ=2'b10, SEQ=2'b11}; BUSY=2'b01 and IDLE=2'b00 are never accepted.
REQ-025 SHALL implement a burst FSM with states IDLE, FIXED and INCR.
REQ-026 SHALL use fixed burst lengths WRAP4/INCR4=4, WRAP8/INCR8=8 and WRAP16/INCR16=16; SINGLE=000 is length 1 and is not tracked.
REQ-027 On accepted NONSEQ (any state), the FSM SHALL go to FIXED with BEATS_LEFT=len-1 for a fixed burst, to INCR for HBURST=INCR (001), and to IDLE for SINGLE.
REQ-028 In FIXED, an accepted SEQ SHALL decrement BEATS_LEFT; the beat that takes it from 1 to 0 SHALL return the FSM to IDLE.
REQ-029 In INCR, accepted SEQ SHALL keep the FSM in INCR.
REQ-030 In FIXED with BEATS_LEFT>0, EARLY_TERM SHALL pulse on any of: accepted NONSEQ; HREADY=1 with HTRANS=IDLE; HREADY=1 with HMASTER differing from the burst owner.
REQ-031 On an HTRANS=IDLE or master-change early termination, the FSM SHALL go to IDLE.
REQ-032 An accepted NONSEQ in FIXED SHALL pulse EARLY_TERM and restart tracking per REQ-027 in the same edge.
REQ-033 In INCR, HREADY=1 with HTRANS=IDLE or a master change SHALL return the FSM to IDLE without EARLY_TERM.
REQ-034 SEQ_ERR SHALL pulse when a SEQ is accepted in IDLE; the FSM SHALL stay in IDLE.
REQ-035 While HREADY=0, FSM state, BEATS_LEFT and the burst-owner register SHALL hold.
REQ-036 BURST_ACTIVE SHALL be 1 exactly in FIXED or INCR; BEATS_LEFT SHALL be 0 outside FIXED.

Reset
REQ-037 On HRESET=1, HMASTER_D, the burst owner and BEATS_LEFT SHALL clear to 0 immediately (asynchronously).
REQ-038 On HRESET=1, the FSM SHALL go to IDLE and BURST_ACTIVE, EARLY_TERM and SEQ_ERR SHALL go to 0 immediately.
REQ-039 Reset asserted mid-burst SHALL abandon the burst without an EARLY_TERM pulse.
REQ-040 The first accepted transfer after reset deassertion SHALL be treated from IDLE.

Structure
REQ-041 Package ahb_pkg SHALL hold the htrans_t and hburst_t enums, the burst-state enum, and a burst-length function.
REQ-042 Sub-module ahb_burst_tracker SHALL contain the FSM, BEATS_LEFT, the owner register and the pulse flops.
REQ-043 The top level SHALL hold only the muxes and HMASTER_D.

Verification
REQ-044 HMASTER=3, HADDRx[3]=0x1000, HREADY=1 -> HADDR=0x1000 in the same cycle; HMASTER_D=3 after the next edge; HWDATA=HWDATAx[3].
REQ-045 Master 2 issues INCR4 NONSEQ then 3 SEQ, HREADY=1 -> BEATS_LEFT 3,2,1,0; BURST_ACTIVE falls after the 4th beat; no pulses.
REQ-046 INCR8 with HREADY=0 for 3 cycles after beat 2 -> BEATS_LEFT holds at 6 and HMASTER_D holds during the stall.
REQ-047 INCR16 from master 1, HMASTER switches to 5 after beat 4 (HREADY=1) -> EARLY_TERM single pulse; FSM IDLE.
REQ-048 SEQ from master 0 directly after reset -> SEQ_ERR pulse; BURST_ACTIVE stays 0.
REQ-049 HMASTER=15 with NMASTERS=8 -> HTRANS=0 and HADDR=0; HRESET asserted mid-WRAP8 -> all outputs 0 immediately.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB types for the master mux and its burst tracker:
//   transfer-type and burst-type encodings, burst-tracker states and a
//   helper that returns the fixed beat count of a burst type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    BST_IDLE  = 2'b00,
    BST_FIXED = 2'b01,
    BST_INCR  = 2'b10
  } burst_state_t;

  // Beat count of a burst type. SINGLE and undefined-length INCR report 1;
  // callers only use the result for the fixed-length types.
  function automatic logic [4:0] burst_len(input hburst_t b);
    logic [4:0] len;
    case (b)
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// ahb_burst_tracker
//   Follows the granted master's burst on the muxed address/control bus and
//   flags protocol anomalies.
//   Ports:
//     clk, rst         clock, asynchronous active-high reset
//     hready           transfer-complete handshake; all state holds while 0
//     htrans, hburst   muxed transfer type / burst type of the granted master
//     hmaster          granted master index
//     burst_active     1 while a FIXED or INCR burst is tracked
//     beats_left       beats remaining in a fixed-length burst (0 otherwise)
//     early_term       one-cycle pulse: fixed burst cut short
//     seq_err          one-cycle pulse: SEQ accepted with no burst tracked
//
//   state | meaning
//   IDLE  | no burst tracked; an accepted SEQ here is an error
//   FIXED | fixed-length burst in progress, beats_left counts down
//   INCR  | undefined-length INCR burst in progress
module ahb_burst_tracker
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hready,
  input  htrans_t    htrans,
  input  hburst_t    hburst,
  input  logic [3:0] hmaster,
  output logic       burst_active,
  output logic [3:0] beats_left,
  output logic       early_term,
  output logic       seq_err
);

  burst_state_t state_q, state_d;
  logic [3:0]   beats_q, beats_d;
  logic [3:0]   owner_q, owner_d;
  logic         early_term_q, early_term_d;
  logic         seq_err_q, seq_err_d;
  logic [4:0]   len;

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    owner_d      = owner_q;
    early_term_d = 1'b0;
    seq_err_d    = 1'b0;
    len          = burst_len(hburst);

    if (hready) begin
      if (htrans == HTRANS_NONSEQ) begin
        // A new burst always restarts tracking, even mid-burst; cutting a
        // fixed burst short this way is reported in the same edge.
        if (state_q == BST_FIXED && beats_q != 4'd0) early_term_d = 1'b1;
        owner_d = hmaster;
        beats_d = 4'd0;
        case (hburst)
          HBURST_SINGLE: state_d = BST_IDLE;
          HBURST_INCR:   state_d = BST_INCR;
          default: begin
            state_d = BST_FIXED;
            beats_d = 4'(len - 5'd1);
          end
        endcase
      end else begin
        case (state_q)
          BST_IDLE: begin
            if (htrans == HTRANS_SEQ) seq_err_d = 1'b1;
          end
          BST_FIXED: begin
            // Losing the grant or going IDLE before the last beat ends the
            // burst early. BUSY simply holds the count.
            if (hmaster != owner_q || htrans == HTRANS_IDLE) begin
              early_term_d = 1'b1;
              state_d      = BST_IDLE;
              beats_d      = 4'd0;
            end else if (htrans == HTRANS_SEQ) begin
              beats_d = beats_q - 4'd1;
              if (beats_q == 4'd1) state_d = BST_IDLE;
            end
          end
          BST_INCR: begin
            if (hmaster != owner_q || htrans == HTRANS_IDLE) state_d = BST_IDLE;
          end
          default: begin
            state_d = BST_IDLE;
            beats_d = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BST_IDLE;
      beats_q      <= 4'd0;
      owner_q      <= 4'd0;
      early_term_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      owner_q      <= owner_d;
      early_term_q <= early_term_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign burst_active = (state_q != BST_IDLE);
  assign beats_left   = beats_q;
  assign early_term   = early_term_q;
  assign seq_err      = seq_err_q;

endmodule

// File: rtl/ahb_master_mux.sv
// ahb_master_mux
//   AHB multi-master bus mux. Address/control is selected combinationally
//   by the granted master (HMASTER); write data is selected by the
//   data-phase master (HMASTER_D), which follows HMASTER on each completed
//   transfer. A burst tracker watches the muxed bus for early termination
//   and stray SEQ transfers.
//   Ports:
//     HCLK, HRESET                    clock, asynchronous active-high reset
//     HMASTER, HREADY                 grant from arbiter, transfer handshake
//     HADDRx..HWDATAx                 per-master buses, master i in slice i
//     HADDR, HTRANS, HWRITE,
//     HSIZE, HBURST, HWDATA           muxed bus (0 for out-of-range master)
//     HMASTER_D                       data-phase master
//     BURST_ACTIVE, BEATS_LEFT        burst tracking status
//     EARLY_TERM, SEQ_ERR             registered one-cycle error pulses
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter int NMASTERS = 16,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [3:0]             HMASTER,
  input  logic                   HREADY,
  input  logic [NMASTERS*AW-1:0] HADDRx,
  input  logic [NMASTERS*2-1:0]  HTRANSx,
  input  logic [NMASTERS-1:0]    HWRITEx,
  input  logic [NMASTERS*3-1:0]  HSIZEx,
  input  logic [NMASTERS*3-1:0]  HBURSTx,
  input  logic [NMASTERS*DW-1:0] HWDATAx,
  output logic [AW-1:0]          HADDR,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [DW-1:0]          HWDATA,
  output logic [3:0]             HMASTER_D,
  output logic                   BURST_ACTIVE,
  output logic [3:0]             BEATS_LEFT,
  output logic                   EARLY_TERM,
  output logic                   SEQ_ERR
);

  logic [3:0] dmaster_q, dmaster_d;

  // Address/control mux; no slice matches an out-of-range master, so the
  // bus reads as all zeros (HTRANS = IDLE).
  always_comb begin
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HBURST = 3'd0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (int'(HMASTER) == i) begin
        HADDR  = HADDRx[i*AW +: AW];
        HTRANS = HTRANSx[i*2 +: 2];
        HWRITE = HWRITEx[i];
        HSIZE  = HSIZEx[i*3 +: 3];
        HBURST = HBURSTx[i*3 +: 3];
      end
    end
  end

  always_comb begin
    HWDATA = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (int'(dmaster_q) == i) HWDATA = HWDATAx[i*DW +: DW];
    end
  end

  always_comb begin
    dmaster_d = dmaster_q;
    if (HREADY) dmaster_d = HMASTER;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) dmaster_q <= 4'd0;
    else        dmaster_q <= dmaster_d;
  end

  assign HMASTER_D = dmaster_q;

  ahb_burst_tracker u_tracker (
    .clk          (HCLK),
    .rst          (HRESET),
    .hready       (HREADY),
    .htrans       (htrans_t'(HTRANS)),
    .hburst       (hburst_t'(HBURST)),
    .hmaster      (HMASTER),
    .burst_active (BURST_ACTIVE),
    .beats_left   (BEATS_LEFT),
    .early_term   (EARLY_TERM),
    .seq_err      (SEQ_ERR)
  );

endmodule

// File: tb/tb_ahb_master_mux.sv
module tb_ahb_master_mux;

  localparam int NM  = 16;
  localparam int NM8 = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_WRAP4 = 3'b010,
                         B_INCR4 = 3'b011, B_WRAP8 = 3'b100, B_INCR8 = 3'b101,
                         B_INCR16 = 3'b111;

  logic              clk;
  logic              rst;
  logic [3:0]        hmaster;
  logic              hready;
  logic [NM*AW-1:0]  haddrx;
  logic [NM*2-1:0]   htransx;
  logic [NM-1:0]     hwritex;
  logic [NM*3-1:0]   hsizex;
  logic [NM*3-1:0]   hburstx;
  logic [NM*DW-1:0]  hwdatax;

  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize, hburst;
  logic [DW-1:0] hwdata;
  logic [3:0]    hmaster_d;
  logic          burst_active;
  logic [3:0]    beats_left;
  logic          early_term, seq_err;

  logic [AW-1:0] haddr8;
  logic [1:0]    htrans8;
  logic          hwrite8;
  logic [2:0]    hsize8, hburst8;
  logic [DW-1:0] hwdata8;
  logic [3:0]    hmaster_d8;
  logic          burst_active8;
  logic [3:0]    beats_left8;
  logic          early_term8, seq_err8;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] md;
    logic       act;
    logic [3:0] bl;
    logic       et;
    logic       se;
  } exp_t;

  exp_t sb[$];

  ahb_master_mux #(.NMASTERS(NM), .AW(AW), .DW(DW)) dut (
    .HCLK(clk), .HRESET(rst), .HMASTER(hmaster), .HREADY(hready),
    .HADDRx(haddrx), .HTRANSx(htransx), .HWRITEx(hwritex), .HSIZEx(hsizex),
    .HBURSTx(hburstx), .HWDATAx(hwdatax),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HMASTER_D(hmaster_d), .BURST_ACTIVE(burst_active),
    .BEATS_LEFT(beats_left), .EARLY_TERM(early_term), .SEQ_ERR(seq_err)
  );

  ahb_master_mux #(.NMASTERS(NM8), .AW(AW), .DW(DW)) dut8 (
    .HCLK(clk), .HRESET(rst), .HMASTER(hmaster), .HREADY(hready),
    .HADDRx(haddrx[NM8*AW-1:0]), .HTRANSx(htransx[NM8*2-1:0]),
    .HWRITEx(hwritex[NM8-1:0]), .HSIZEx(hsizex[NM8*3-1:0]),
    .HBURSTx(hburstx[NM8*3-1:0]), .HWDATAx(hwdatax[NM8*DW-1:0]),
    .HADDR(haddr8), .HTRANS(htrans8), .HWRITE(hwrite8), .HSIZE(hsize8), .HBURST(hburst8),
    .HWDATA(hwdata8), .HMASTER_D(hmaster_d8), .BURST_ACTIVE(burst_active8),
    .BEATS_LEFT(beats_left8), .EARLY_TERM(early_term8), .SEQ_ERR(seq_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic [1:0] tr, input logic [2:0] bu);
    htransx[m*2 +: 2] = tr;
    hburstx[m*3 +: 3] = bu;
  endtask

  task automatic push(input string tag, input logic [3:0] md, input logic act,
                      input logic [3:0] bl, input logic et, input logic se);
    exp_t e;
    e.tag = tag; e.md = md; e.act = act; e.bl = bl; e.et = et; e.se = se;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare the registered outputs with the oldest
  // pending expectation.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".hmaster_d"},    32'(hmaster_d),    32'(e.md));
      chk({e.tag, ".burst_active"}, 32'(burst_active), 32'(e.act));
      chk({e.tag, ".beats_left"},   32'(beats_left),   32'(e.bl));
      chk({e.tag, ".early_term"},   32'(early_term),   32'(e.et));
      chk({e.tag, ".seq_err"},      32'(seq_err),      32'(e.se));
    end
  endtask

  initial begin
    rst     = 1'b1;
    hmaster = 4'd0;
    hready  = 1'b1;
    haddrx  = '0;
    htransx = '0;
    hwritex = '0;
    hsizex  = '0;
    hburstx = '0;
    hwdatax = '0;
    for (int i = 0; i < NM; i++) begin
      haddrx[i*AW +: AW]  = 32'h0000_0100 * (i + 1);
      hwdatax[i*DW +: DW] = 32'hD000_0000 + i;
      hwritex[i]          = i[0];
      hsizex[i*3 +: 3]    = 3'd2;
    end
    haddrx[3*AW +: AW] = 32'h0000_1000;

    #12;
    chk("reset.hmaster_d",    32'(hmaster_d),    32'd0);
    chk("reset.burst_active", 32'(burst_active), 32'd0);
    chk("reset.beats_left",   32'(beats_left),   32'd0);
    chk("reset.early_term",   32'(early_term),   32'd0);
    chk("reset.seq_err",      32'(seq_err),      32'd0);
    rst = 1'b0;

    // SEQ straight out of reset
    set_m(0, T_SEQ, B_INCR4);
    push("seq_after_reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick_check();
    set_m(0, T_IDLE, B_SINGLE);
    push("seq_err_clear", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    // Zero-latency address mux, data-phase master follows on the edge
    hmaster = 4'd3;
    #1;
    chk("addr_mux.haddr",   haddr,  32'h0000_1000);
    chk("addr_mux.hwrite",  32'(hwrite), 32'd1);
    chk("addr_mux.hwdata0", hwdata, 32'hD000_0000);
    push("dphase_m3", 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();
    chk("dphase.hwdata3", hwdata, 32'hD000_0003);

    // INCR4 from master 2, runs to completion
    hmaster = 4'd2;
    set_m(2, T_NSEQ, B_INCR4);
    push("incr4_b1", 4'd2, 1'b1, 4'd3, 1'b0, 1'b0);
    tick_check();
    set_m(2, T_SEQ, B_INCR4);
    push("incr4_b2", 4'd2, 1'b1, 4'd2, 1'b0, 1'b0);
    tick_check();
    push("incr4_b3", 4'd2, 1'b1, 4'd1, 1'b0, 1'b0);
    tick_check();
    push("incr4_b4", 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();
    set_m(2, T_IDLE, B_SINGLE);
    push("incr4_after", 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    // INCR8 with a 3-cycle stall after beat 2, then IDLE cuts it short
    set_m(2, T_NSEQ, B_INCR8);
    push("incr8_b1", 4'd2, 1'b1, 4'd7, 1'b0, 1'b0);
    tick_check();
    set_m(2, T_SEQ, B_INCR8);
    push("incr8_b2", 4'd2, 1'b1, 4'd6, 1'b0, 1'b0);
    tick_check();
    hready  = 1'b0;
    hmaster = 4'd4;
    for (int k = 0; k < 3; k++) begin
      push("incr8_stall", 4'd2, 1'b1, 4'd6, 1'b0, 1'b0);
      tick_check();
    end
    chk("incr8_stall.hwdata", hwdata, 32'hD000_0002);
    hready  = 1'b1;
    hmaster = 4'd2;
    push("incr8_b3", 4'd2, 1'b1, 4'd5, 1'b0, 1'b0);
    tick_check();
    set_m(2, T_IDLE, B_SINGLE);
    push("incr8_idle_term", 4'd2, 1'b0, 4'd0, 1'b1, 1'b0);
    tick_check();
    push("incr8_term_done", 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    // INCR16 from master 1, grant moves to master 5 after beat 4
    hmaster = 4'd1;
    set_m(1, T_NSEQ, B_INCR16);
    push("incr16_b1", 4'd1, 1'b1, 4'd15, 1'b0, 1'b0);
    tick_check();
    set_m(1, T_SEQ, B_INCR16);
    push("incr16_b2", 4'd1, 1'b1, 4'd14, 1'b0, 1'b0);
    tick_check();
    push("incr16_b3", 4'd1, 1'b1, 4'd13, 1'b0, 1'b0);
    tick_check();
    push("incr16_b4", 4'd1, 1'b1, 4'd12, 1'b0, 1'b0);
    tick_check();
    hmaster = 4'd5;
    set_m(5, T_IDLE, B_SINGLE);
    push("incr16_mchg", 4'd5, 1'b0, 4'd0, 1'b1, 1'b0);
    tick_check();
    push("incr16_pulse_end", 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    // Undefined-length INCR ends on IDLE without a pulse
    hmaster = 4'd6;
    set_m(6, T_NSEQ, B_INCR);
    push("incr_start", 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
    tick_check();
    set_m(6, T_SEQ, B_INCR);
    push("incr_seq", 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
    tick_check();
    set_m(6, T_BUSY, B_INCR);
    push("incr_busy", 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
    tick_check();
    set_m(6, T_IDLE, B_SINGLE);
    push("incr_idle", 4'd6, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    // NONSEQ restart inside a fixed burst, BUSY hold, SINGLE termination
    hmaster = 4'd7;
    set_m(7, T_NSEQ, B_WRAP4);
    push("wrap4_start", 4'd7, 1'b1, 4'd3, 1'b0, 1'b0);
    tick_check();
    set_m(7, T_NSEQ, B_INCR8);
    push("restart_incr8", 4'd7, 1'b1, 4'd7, 1'b1, 1'b0);
    tick_check();
    set_m(7, T_BUSY, B_INCR8);
    push("fixed_busy", 4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
    tick_check();
    set_m(7, T_NSEQ, B_SINGLE);
    push("single_term", 4'd7, 1'b0, 4'd0, 1'b1, 1'b0);
    tick_check();
    set_m(7, T_IDLE, B_SINGLE);
    push("single_after", 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    // Out-of-range master on the 8-master instance
    hmaster = 4'd15;
    set_m(7, T_NSEQ, B_INCR4);
    #1;
    chk("oor8.htrans", 32'(htrans8), 32'd0);
    chk("oor8.haddr",  haddr8,      32'd0);
    chk("oor8.hburst", 32'(hburst8), 32'd0);
    chk("m15.haddr",   haddr,       32'h0000_1000);
    push("oor_dphase", 4'd15, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();
    chk("oor8.hwdata", hwdata8, 32'd0);
    chk("m15.hwdata",  hwdata,  32'hD000_000F);
    set_m(7, T_IDLE, B_SINGLE);

    // Reset mid-WRAP8
    hmaster = 4'd3;
    set_m(3, T_NSEQ, B_WRAP8);
    push("wrap8_b1", 4'd3, 1'b1, 4'd7, 1'b0, 1'b0);
    tick_check();
    set_m(3, T_SEQ, B_WRAP8);
    push("wrap8_b2", 4'd3, 1'b1, 4'd6, 1'b0, 1'b0);
    tick_check();
    rst = 1'b1;
    #1;
    chk("async_rst.hmaster_d",    32'(hmaster_d),    32'd0);
    chk("async_rst.burst_active", 32'(burst_active), 32'd0);
    chk("async_rst.beats_left",   32'(beats_left),   32'd0);
    chk("async_rst.early_term",   32'(early_term),   32'd0);
    chk("async_rst.seq_err",      32'(seq_err),      32'd0);
    push("rst_held", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();
    rst = 1'b0;
    // the burst is gone: a SEQ now is seen from IDLE
    push("post_rst_seq", 4'd3, 1'b0, 4'd0, 1'b0, 1'b1);
    tick_check();
    set_m(3, T_IDLE, B_SINGLE);
    push("post_rst_idle", 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_check();

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
